// File: rtl/dot_product_accumulator.sv
// Sums LEN consecutive unsigned products into one dot-product result, holding it
// until the downstream writer accepts it; flags vectors whose length disagrees with in_last.
module dot_product_accumulator #(
  parameter int PROD_W = 16,
  parameter int LEN    = 8,
  parameter int ACC_W  = 19,
  parameter int CNT_W  = $clog2(LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_err
);

  generate
    if (LEN < 2 || LEN > 256) begin : g_len_chk
      $error("dot_product_accumulator: LEN must be in 2..256");
    end
    if (ACC_W < PROD_W + $clog2(LEN)) begin : g_accw_chk
      $error("dot_product_accumulator: ACC_W too narrow for LEN products");
    end
  endgenerate

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);

  function automatic logic [ACC_W-1:0] widen(input logic [PROD_W-1:0] p);
    return ACC_W'(p);
  endfunction

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             at_end;
  logic             terminate;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  assign accept    = in_valid && in_ready;
  assign at_end    = (cnt == LAST_IDX);
  assign terminate = in_last || at_end;
  assign acc_nxt   = acc + widen(in_product);
  assign cnt_nxt   = cnt + CNT_W'(1);

  // in_ready/out_valid are registered alongside state so neither depends on an input combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      out_sum   <= '0;
      out_count <= '0;
      out_err   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (terminate) begin
              out_sum   <= acc_nxt;
              out_count <= cnt_nxt;
              out_err   <= in_last ^ at_end;
              acc       <= '0;
              cnt       <= '0;
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              acc <= acc_nxt;
              cnt <= cnt_nxt;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ACCUM;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench for dot_product_accumulator with hand-computed expected sums.
module tb_dot_product_accumulator;

  localparam int PROD_W = 16;
  localparam int LEN    = 8;
  localparam int ACC_W  = 19;
  localparam int CNT_W  = $clog2(LEN + 1);

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_err;

  int n_checks = 0;
  int n_fail   = 0;

  dot_product_accumulator #(
    .PROD_W(PROD_W), .LEN(LEN), .ACC_W(ACC_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One product presented for exactly one accepting edge.
  task automatic put(input logic [PROD_W-1:0] p, input logic last);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) check("put_ready_timeout", 32'(in_ready), 32'd1);
    in_valid   = 1'b1;
    in_product = p;
    in_last    = last;
    tick();
    in_valid   = 1'b0;
    in_last    = 1'b0;
  endtask

  task automatic put_n(input int n, input logic [PROD_W-1:0] p, input logic last_on_final);
    for (int i = 0; i < n; i++) put(p, last_on_final && (i == n - 1));
  endtask

  // Sampled right after the terminating accept: result must already be valid.
  task automatic expect_result(input string tag, input int sum, input int count, input int err);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"},   32'(out_sum),   32'(sum));
    check({tag, "_count"}, 32'(out_count), 32'(count));
    check({tag, "_err"},   32'(out_err),   32'(err));
    check({tag, "_inrdy0"}, 32'(in_ready), 32'd0);
    if (out_ready) begin
      tick();
      check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_inrdy1"},     32'(in_ready),  32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b1;
    in_product = 16'd123;
    in_last    = 1'b0;
    out_ready  = 1'b1;
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sum",   32'(out_sum),   32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_err",   32'(out_err),   32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    check("rst_inrdy", 32'(in_ready), 32'd1);

    // Nominal vector, one-cycle latency
    put(16'd200, 1'b0);
    put(16'd1200, 1'b0);
    put(16'd2000, 1'b0);
    put_n(4, 16'd0, 1'b0);
    check("nom_not_yet", 32'(out_valid), 32'd0);
    put(16'd0, 1'b1);
    expect_result("nom", 3400, 8, 0);

    put_n(8, 16'd65025, 1'b1);
    expect_result("max", 520200, 8, 0);

    put(16'd200, 1'b0);
    put(16'd1200, 1'b0);
    put(16'd2000, 1'b1);
    expect_result("short", 3400, 3, 1);

    put_n(8, 16'd10, 1'b0);
    expect_result("nolast", 80, 8, 1);

    // Backpressure: held result is stable and nothing is consumed
    out_ready = 1'b0;
    put_n(3, 16'd7, 1'b1);
    expect_result("bp", 21, 3, 1);
    in_valid   = 1'b1;
    in_product = 16'd999;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_sum",   32'(out_sum),   32'd21);
      check("bp_hold_count", 32'(out_count), 32'd3);
      check("bp_hold_inrdy", 32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release", 32'(out_valid), 32'd0);
    put_n(8, 16'd1, 1'b1);
    expect_result("bp_next", 8, 8, 0);

    // Reset mid-vector discards the partial sum
    put_n(3, 16'd500, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_sum",   32'(out_sum),   32'd0);
    put_n(8, 16'd2, 1'b1);
    expect_result("midrst", 16, 8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dot_product_accumulator.md
Name: dot_product_accumulator

Overview:
- Consumes the 16-bit products from the 8-bit Wallace tree multiplier and sums LEN consecutive products into one dot-product result. Each result is one matrix-multiply output element.
- Sits directly downstream of the multiplier, using valid/ready on both sides.
- The result is held until the downstream writer (result buffer) accepts it. Vector-length mismatches against the upstream in_last marker are flagged.

Parameters:
- PROD_W, 16, width of incoming product.
- LEN, 8, nominal elements per dot product; legal range 2..256.
- ACC_W, 19, accumulator/result width; must be >= PROD_W + $clog2(LEN), enforced by elaboration-time check.
- CNT_W, $clog2(LEN+1), width of out_count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  product valid.
- in_ready  output  1  block can accept a product.
- in_product  input  PROD_W  unsigned product from multiplier.
- in_last  input  1  upstream marks final element of the vector.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  ACC_W  unsigned dot-product sum.
- out_count  output  CNT_W  number of products summed into out_sum.
- out_err  output  1  length mismatch for this result.

Behaviour:
- Two states:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Reset (rst=1 at clk edge), regardless of state:
  - state=ACCUM, acc=0, cnt=0.
  - out_sum=0, out_count=0, out_err=0, out_valid=0, in_ready=1 from the first cycle after reset.
  - A partially accumulated vector is discarded.
- Accept event is in_valid && in_ready. in_product is don't-care when not accepted.
- ACCUM, on accept, when neither in_last nor cnt==LEN-1: acc <= acc + in_product; cnt <= cnt+1.
- ACCUM, on accept with in_last=1 or cnt==LEN-1 (terminating element):
  - out_sum <= acc + in_product; out_count <= cnt+1.
  - out_err <= (in_last XOR (cnt==LEN-1)).
  - acc <= 0, cnt <= 0, state <= HOLD.
- Termination rules:
  - Early in_last ends the vector short, with err=1.
  - Reaching LEN without in_last ends the vector, with err=1.
- Latency: out_valid asserts the cycle after the terminating accept. Throughput is one result per (elements + 1) cycles minimum.
- HOLD:
  - out_sum, out_count and out_err are stable while out_valid=1 and out_ready=0.
  - in_valid is ignored; no product is consumed.
  - On out_valid && out_ready: state <= ACCUM, out_valid <= 0. out_sum, out_count and out_err retain their value but are don't-care.
- Arithmetic: unsigned, zero-extended to ACC_W; no saturation. With the parameter constraint, overflow cannot occur: max 8*65535 = 524280 < 2^19.
- No combinational path from in_valid to in_ready or from out_ready to out_valid; in_ready is a decode of state only.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_sum=0, out_count=0, out_err=0; in_ready=1 the cycle after rst drops.
- Nominal, with out_ready=1:
  - Stimulus: products 200,1200,2000,0,0,0,0,0 on consecutive cycles, in_last on the 8th.
  - Response: out_valid=1 exactly one cycle after the 8th accept; out_sum=3400, out_count=8, out_err=0; in_ready=0 that cycle, 1 the next.
- Max value: 8 products of 65025 with in_last on the 8th -> out_sum=520200, out_count=8, out_err=0 (no wrap).
- Length mismatches:
  - Products 200,1200,2000 with in_last on the 3rd -> out_sum=3400, out_count=3, out_err=1.
  - 8 products of 10 with in_last never asserted -> out_sum=80, out_count=8, out_err=1.
- Backpressure:
  - Stimulus: after a result, out_ready=0 for 5 cycles while in_valid=1 with product 999.
  - Response: out_valid stays 1, out_sum unchanged, in_ready=0, no product consumed.
  - Then out_ready=1; the next vector of 8 products of 1 gives out_sum=8 (accumulator restarted from 0).
- Reset mid-vector: accept 3 products of 500, assert rst one cycle, then send 8 products of 2 with in_last on the 8th -> out_sum=16, out_count=8, out_err=0.
